nibble_rx: RTL

- Serial-to-parallel receiver sitting directly upstream of the 4-bit clock-enabled holding register.
- Deserialises an asynchronous-style frame on SIN: 1 start bit (0), NBITS data bits LSB first, 1 stop bit (1).
- Presents the assembled word on DOUT with a one-cycle LOAD strobe, which drives the register's CE; DOUT drives its Din.
- Flags bad stop bits on FERR; a bad frame never produces LOAD.

---
 rtl/nibble_rx_pkg.sv | 15 +
 rtl/nibble_rx_sync.sv | 31 +++
 rtl/nibble_rx.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/nibble_rx_pkg.sv
// nibble_rx_pkg: shared definitions for the nibble_rx serial receiver.
// Holds the receiver FSM state encoding and the default frame parameters.
package nibble_rx_pkg;

    localparam int NBITS_DEF = 4;   // data bits per frame
    localparam int OVS_DEF   = 4;   // TICK periods per bit

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

endpackage

// File: rtl/nibble_rx_sync.sv
// nibble_rx_sync: two-flop synchroniser for an asynchronous single-bit input.
// Both flops reset to 1, which is the idle level of a serial line.
// Ports:
//   clk - sampling clock, every rising edge (not enable-gated)
//   rst - asynchronous active-high reset
//   d   - asynchronous input
//   q   - synchronised output, d delayed by two clk edges
module nibble_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/nibble_rx.sv
// nibble_rx: serial-to-parallel receiver feeding a clock-enabled holding register.
// Frame on SIN: start bit (0), NBITS data bits LSB first, stop bit (1).
// All bit timing advances only on TICK-qualified CLK cycles.
// Ports:
//   CLK  - system clock
//   RST  - asynchronous active-high reset
//   SIN  - serial line, idle high, asynchronous to CLK
//   TICK - one-CLK sample enable, OVS ticks per bit
//   DOUT - last good received word, held between frames
//   LOAD - one-CLK pulse when DOUT is newly valid
//   FERR - one-CLK pulse when the stop bit was sampled low
//   BUSY - high whenever the receiver is not idle
module nibble_rx
    import nibble_rx_pkg::*;
#(
    parameter int NBITS = NBITS_DEF,
    parameter int OVS   = OVS_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SIN,
    input  logic             TICK,
    output logic [NBITS-1:0] DOUT,
    output logic             LOAD,
    output logic             FERR,
    output logic             BUSY
);

    localparam int TW = (OVS > 1) ? $clog2(OVS) : 1;
    localparam int BW = $clog2(NBITS + 1);

    // Tick index of the mid-bit re-sample in START, and of the bit sample elsewhere
    localparam logic [TW-1:0] HALF_LAST = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(OVS - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(NBITS - 1);

    logic             s_in;
    state_t           state_r, state_nx;
    logic [TW-1:0]    tick_cnt_r, tick_cnt_nx;
    logic [BW-1:0]    bit_cnt_r, bit_cnt_nx;
    logic [NBITS-1:0] shift_r, shift_nx;
    logic [NBITS:0]   shift_ext_s;
    logic [NBITS-1:0] dout_r, dout_nx;
    logic             load_r, load_nx;
    logic             ferr_r, ferr_nx;
    logic             busy_r, busy_nx;

    nibble_rx_sync u_sin_sync (
        .clk (CLK),
        .rst (RST),
        .d   (SIN),
        .q   (s_in)
    );

    // Next-state, counter, shift and output decode; only TICK cycles advance
    always_comb begin
        state_nx    = state_r;
        tick_cnt_nx = tick_cnt_r;
        bit_cnt_nx  = bit_cnt_r;
        shift_nx    = shift_r;
        dout_nx     = dout_r;
        load_nx     = 1'b0;
        ferr_nx     = 1'b0;
        // New sample enters at the MSB; after NBITS shifts bit 0 is the first bit
        shift_ext_s = {s_in, shift_r};
        if (TICK) begin
            case (state_r)
                IDLE: begin
                    if (!s_in) begin
                        state_nx    = START;
                        tick_cnt_nx = {TW{1'b0}};
                    end else begin
                        state_nx    = IDLE;
                    end
                end
                START: begin
                    if (tick_cnt_r == HALF_LAST) begin
                        if (s_in) begin
                            state_nx    = IDLE;   // false start
                        end else begin
                            state_nx    = DATA;
                            tick_cnt_nx = {TW{1'b0}};
                            bit_cnt_nx  = {BW{1'b0}};
                        end
                    end else begin
                        tick_cnt_nx = tick_cnt_r + TW'(1);
                    end
                end
                DATA: begin
                    if (tick_cnt_r == BIT_LAST) begin
                        shift_nx    = shift_ext_s[NBITS:1];
                        tick_cnt_nx = {TW{1'b0}};
                        if (bit_cnt_r == DATA_LAST) begin
                            state_nx   = STOP;
                            bit_cnt_nx = {BW{1'b0}};
                        end else begin
                            bit_cnt_nx = bit_cnt_r + BW'(1);
                        end
                    end else begin
                        tick_cnt_nx = tick_cnt_r + TW'(1);
                    end
                end
                STOP: begin
                    if (tick_cnt_r == BIT_LAST) begin
                        state_nx    = IDLE;
                        tick_cnt_nx = {TW{1'b0}};
                        if (s_in) begin
                            dout_nx = shift_r;
                            load_nx = 1'b1;
                        end else begin
                            ferr_nx = 1'b1;
                        end
                    end else begin
                        tick_cnt_nx = tick_cnt_r + TW'(1);
                    end
                end
                default: begin
                    state_nx    = IDLE;
                    tick_cnt_nx = {TW{1'b0}};
                    bit_cnt_nx  = {BW{1'b0}};
                end
            endcase
        end else begin
            state_nx = state_r;
        end
        busy_nx = (state_nx != IDLE);
    end

    // State, counters, shift register and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r    <= IDLE;
            tick_cnt_r <= {TW{1'b0}};
            bit_cnt_r  <= {BW{1'b0}};
            shift_r    <= {NBITS{1'b0}};
            dout_r     <= {NBITS{1'b0}};
            load_r     <= 1'b0;
            ferr_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nx;
            tick_cnt_r <= tick_cnt_nx;
            bit_cnt_r  <= bit_cnt_nx;
            shift_r    <= shift_nx;
            dout_r     <= dout_nx;
            load_r     <= load_nx;
            ferr_r     <= ferr_nx;
            busy_r     <= busy_nx;
        end
    end

    assign DOUT = dout_r;
    assign LOAD = load_r;
    assign FERR = ferr_r;
    assign BUSY = busy_r;

endmodule
